// File: rtl/conv_pool_stream.sv
// Streaming NCH-channel 4x4-tile 3x3 convolution, shift/clamp and 2x2 pooling in a 3-stage stall-able pipeline.
// Define CONV_POOL_SAT_CNT_EN to add the sat_cnt output (count of transfers whose beat saturated high).
module conv_pool_stream #(
    parameter int NCH    = 3,
    parameter int PIX_W  = 8,
    parameter int KW_W   = 8,
    parameter int SHIFT  = 0,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_pool_max,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NCH*16*PIX_W-1:0]  image,
    input  logic [NCH*9*KW_W-1:0]    kernel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PIX_W-1:0]         y,
    output logic [ADDR_W-1:0]        out_idx
`ifdef CONV_POOL_SAT_CNT_EN
    ,output logic [15:0]             sat_cnt
`endif
);
    localparam int SUM_W = PIX_W + KW_W + 1 + $clog2(9 * NCH);
    localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << PIX_W) - 1);

    logic                    en;
    logic signed [SUM_W-1:0] ch_sum_d  [NCH][4];
    logic signed [SUM_W-1:0] ch_sum_q  [NCH][4];
    logic signed [SUM_W-1:0] win_sum_d [4];
    logic signed [SUM_W-1:0] win_sum_q [4];
    logic                    s1_valid_q, s1_max_q;
    logic                    s2_valid_q, s2_max_q;
    logic                    out_valid_q;
    logic [PIX_W-1:0]        y_d, y_q;
    logic [ADDR_W-1:0]       idx_q;
    logic signed [SUM_W-1:0] s_val;
    logic [PIX_W-1:0]        clamp_val, max_val;
    logic [PIX_W+1:0]        avg_acc;

    // Whole pipeline advances together; any stage can only move when the output slot frees up.
    assign en        = !out_valid_q || out_ready;
    assign in_ready  = rst && en;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign out_idx   = idx_q;

    function automatic logic signed [SUM_W-1:0] conv_win(
        input logic [16*PIX_W-1:0] tile,
        input logic [9*KW_W-1:0]   kern,
        input int                  a,
        input int                  b
    );
        logic signed [SUM_W-1:0] acc, pix, wgt;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                pix = SUM_W'($signed({1'b0, tile[((a + i) * 4 + b + j) * PIX_W +: PIX_W]}));
                wgt = SUM_W'($signed(kern[(i * 3 + j) * KW_W +: KW_W]));
                acc = acc + pix * wgt;
            end
        end
        return acc;
    endfunction

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        for (genvar wi = 0; wi < 4; wi++) begin : g_win
            assign ch_sum_d[gi][wi] = conv_win(image[gi*16*PIX_W +: 16*PIX_W],
                                               kernel[gi*9*KW_W +: 9*KW_W], wi / 2, wi % 2);
        end
    end

    always_comb begin
        for (int w = 0; w < 4; w++) begin
            win_sum_d[w] = '0;
            for (int c = 0; c < NCH; c++) begin
                win_sum_d[w] = win_sum_d[w] + ch_sum_q[c][w];
            end
        end
    end

    always_comb begin
        avg_acc   = '0;
        max_val   = '0;
        s_val     = '0;
        clamp_val = '0;
        for (int w = 0; w < 4; w++) begin
            s_val = win_sum_q[w] >>> SHIFT;
            if (s_val < 0)            clamp_val = '0;
            else if (s_val > PIX_MAX) clamp_val = '1;
            else                      clamp_val = s_val[PIX_W-1:0];
            avg_acc = avg_acc + (PIX_W+2)'(clamp_val);
            if (clamp_val > max_val) max_val = clamp_val;
        end
        y_d = s2_max_q ? max_val : avg_acc[PIX_W+1:2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                for (int w = 0; w < 4; w++) ch_sum_q[c][w] <= '0;
            end
            for (int w = 0; w < 4; w++) win_sum_q[w] <= '0;
            s1_valid_q  <= 1'b0;
            s1_max_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_max_q    <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            idx_q       <= '0;
        end else begin
            if (en) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    ch_sum_q <= ch_sum_d;
                    s1_max_q <= cfg_pool_max;
                end
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    win_sum_q <= win_sum_d;
                    s2_max_q  <= s1_max_q;
                end
                out_valid_q <= s2_valid_q;
                if (s2_valid_q) y_q <= y_d;
            end
            if (out_valid_q && out_ready) idx_q <= idx_q + ADDR_W'(1);
        end
    end

`ifdef CONV_POOL_SAT_CNT_EN
    logic        sat_d, sat_q;
    logic [15:0] sat_cnt_q;

    always_comb begin
        sat_d = 1'b0;
        for (int w = 0; w < 4; w++) begin
            if ((win_sum_q[w] >>> SHIFT) > PIX_MAX) sat_d = 1'b1;
        end
    end

    // The flag rides alongside y so the count tracks the beat actually being transferred.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q     <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            if (en && s2_valid_q) sat_q <= sat_d;
            if (out_valid_q && out_ready && sat_q && sat_cnt_q != 16'hFFFF)
                sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif
endmodule

// File: tb/tb_conv_pool_stream.sv
// Self-checking bench for conv_pool_stream: directed cases, stalls, index wrap, random traffic, mid-stream reset.
`timescale 1ns/1ps
module tb_conv_pool_stream;
    localparam int NCH   = 3;
    localparam int PIX_W = 8;
    localparam int KW_W  = 8;
    localparam int SHIFT = 0;
    localparam int IMG_W = NCH * 16 * PIX_W;
    localparam int KER_W = NCH * 9 * KW_W;
    localparam int PMAX  = (1 << PIX_W) - 1;

    logic clk = 1'b0, rst = 1'b0, cfg_pool_max = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [IMG_W-1:0] image  = '0;
    logic [KER_W-1:0] kernel = '0;
    logic in_ready, out_valid, in_ready2, out_valid2;
    logic [PIX_W-1:0] y, y2;
    logic [15:0] out_idx;
    logic [3:0]  out_idx2;
`ifdef CONV_POOL_SAT_CNT_EN
    logic [15:0] sat_cnt, sat_cnt2;
`endif

    int checks = 0, passed = 0;

    typedef struct { int y; bit sat; } exp_t;
    typedef struct {
        bit have_exp; int exp_y; int got_y; int got_idx; int got_idx2; int want_idx;
    } pair_t;
    exp_t  exp_q[$];
    pair_t pairs[$];
    int tr_num = 0, ref_sat = 0;

    always #5 clk = ~clk;

    conv_pool_stream #(.NCH(NCH), .PIX_W(PIX_W), .KW_W(KW_W), .SHIFT(SHIFT), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_pool_max(cfg_pool_max), .in_valid(in_valid), .in_ready(in_ready),
        .image(image), .kernel(kernel), .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .out_idx(out_idx)
`ifdef CONV_POOL_SAT_CNT_EN
        , .sat_cnt(sat_cnt)
`endif
    );

    conv_pool_stream #(.NCH(NCH), .PIX_W(PIX_W), .KW_W(KW_W), .SHIFT(SHIFT), .ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst), .cfg_pool_max(cfg_pool_max), .in_valid(in_valid), .in_ready(in_ready2),
        .image(image), .kernel(kernel), .out_valid(out_valid2), .out_ready(out_ready), .y(y2),
        .out_idx(out_idx2)
`ifdef CONV_POOL_SAT_CNT_EN
        , .sat_cnt(sat_cnt2)
`endif
    );

    // Reference: direct evaluation of the conv / clamp / pool arithmetic for one beat.
    function automatic void model(input logic [IMG_W-1:0] img, input logic [KER_W-1:0] ker,
                                  input logic mx, output int yv, output bit sat);
        int conv, s, total, best, p;
        logic signed [KW_W-1:0] w;
        sat = 0; total = 0; best = 0;
        for (int a = 0; a < 2; a++) begin
            for (int b = 0; b < 2; b++) begin
                conv = 0;
                for (int ch = 0; ch < NCH; ch++)
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++) begin
                            p = int'(img[(ch*16 + (a+i)*4 + b + j) * PIX_W +: PIX_W]);
                            w = ker[(ch*9 + i*3 + j) * KW_W +: KW_W];
                            conv += p * int'(w);
                        end
                s = conv >>> SHIFT;
                if (s < 0) s = 0;
                else if (s > PMAX) begin s = PMAX; sat = 1; end
                total += s;
                if (s > best) best = s;
            end
        end
        yv = mx ? best : total / 4;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (in_valid && in_ready) begin
                exp_t e;
                model(image, kernel, cfg_pool_max, e.y, e.sat);
                exp_q.push_back(e);
            end
            if (out_valid && out_ready) begin
                pair_t p;
                p.have_exp = exp_q.size() > 0;
                p.exp_y = -1;
                if (p.have_exp) begin
                    p.exp_y = exp_q[0].y;
                    if (exp_q[0].sat && ref_sat < 65535) ref_sat++;
                    void'(exp_q.pop_front());
                end
                p.got_y = int'(y); p.got_idx = int'(out_idx); p.got_idx2 = int'(out_idx2);
                p.want_idx = tr_num % 65536;
                tr_num++;
                pairs.push_back(p);
            end
        end
    end

    task automatic put_pix(input int ch, input int k, input int v);
        image[(ch*16 + k) * PIX_W +: PIX_W] = PIX_W'(v);
    endtask

    task automatic put_w(input int ch, input int k, input int v);
        kernel[(ch*9 + k) * KW_W +: KW_W] = KW_W'(v);
    endtask

    task automatic fill_uniform(input int pv, input int cw);
        for (int ch = 0; ch < NCH; ch++) begin
            for (int k = 0; k < 16; k++) put_pix(ch, k, pv);
            for (int k = 0; k < 9; k++) put_w(ch, k, (k == 4) ? cw : 0);
        end
    endtask

    task automatic fill_random();
        for (int ch = 0; ch < NCH; ch++) begin
            for (int k = 0; k < 16; k++) put_pix(ch, k, int'($urandom_range(0, 63)));
            for (int k = 0; k < 9; k++) put_w(ch, k, int'($urandom_range(0, 4)) - 2);
        end
    endtask

    task automatic clear_bench_state();
        exp_q.delete(); pairs.delete(); tr_num = 0; ref_sat = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b0; in_valid = 1'b0;
        clear_bench_state();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic send_beat(input logic mode);
        bit ok = 0;
        cfg_pool_max = mode; in_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin checks++; $display("FAIL send_timeout in_ready stuck at 0 for 200 cycles"); end
    endtask

    task automatic wait_pairs(input int n);
        int t = 0;
        while (pairs.size() < n && t < 500) begin @(posedge clk); #1; t++; end
        if (pairs.size() < n) begin
            checks++; $display("FAIL wait_outputs got=%0d want=%0d transfers", pairs.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%0b want=0", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b want=0", out_valid); else passed++;
        checks++; if (y !== '0) $display("FAIL reset_y got=%0d want=0", y); else passed++;
        checks++; if (out_idx !== '0) $display("FAIL reset_out_idx got=%0d want=0", out_idx); else passed++;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got=%0b want=1", in_ready); else passed++;
        @(posedge clk); #1;
        $display("reset: done");
    endtask

    task automatic test_directed();
        int want_y [5] = '{30, 7, 10, 255, 0};
        bit modes  [5] = '{0, 0, 1, 0, 0};
        int edges;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) fill_uniform(10, 1);
            else if (k <= 2) begin
                fill_uniform(0, 0);
                for (int p = 0; p < 16; p++) put_pix(0, p, p);
                put_w(0, 4, 1);
            end else fill_uniform(200, (k == 3) ? 2 : -1);
            if (k == 0) begin
                cfg_pool_max = 1'b0; in_valid = 1'b1; edges = 0;
                @(negedge clk);
                checks++; if (in_ready !== 1'b1) $display("FAIL lat_in_ready got=%0b want=1", in_ready); else passed++;
                for (int t = 0; t < 10; t++) begin
                    @(posedge clk); #1 in_valid = 1'b0; edges++;
                    @(negedge clk);
                    if (out_valid) break;
                end
                checks++; if (edges != 3) $display("FAIL latency got=%0d want=3 edges", edges); else passed++;
            end else send_beat(modes[k]);
            wait_pairs(1);
            if (pairs.size() > 0) begin
                pair_t p = pairs.pop_front();
                checks++; if (p.got_y != want_y[k]) $display("FAIL directed%0d_y got=%0d want=%0d", k, p.got_y, want_y[k]); else passed++;
                checks++; if (p.got_idx != k) $display("FAIL directed%0d_idx got=%0d want=%0d", k, p.got_idx, k); else passed++;
            end
`ifdef CONV_POOL_SAT_CNT_EN
            if (k >= 3) begin
                checks++; if (sat_cnt !== 16'd1) $display("FAIL directed%0d_sat_cnt got=%0d want=1", k, sat_cnt); else passed++;
            end
`endif
            $display("directed %0d: mode=%0b want_y=%0d", k, modes[k], want_y[k]);
        end
    endtask

    task automatic test_backpressure();
        int stall_y, stall_idx, base;
        out_ready = 1'b0;
        base = tr_num;
        for (int k = 0; k < 3; k++) begin fill_random(); send_beat(k[0]); end
        fill_random(); cfg_pool_max = 1'b1; in_valid = 1'b1;
        stall_y = (exp_q.size() > 0) ? exp_q[0].y : -1;
        stall_idx = tr_num;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) $display("FAIL stall%0d_in_ready got=%0b want=0", c, in_ready); else passed++;
            checks++; if (out_valid !== 1'b1 || int'(y) != stall_y) $display("FAIL stall%0d_y got=%0d/v%0b want=%0d/v1", c, y, out_valid, stall_y); else passed++;
            checks++; if (int'(out_idx) != stall_idx) $display("FAIL stall%0d_idx got=%0d want=%0d", c, out_idx, stall_idx); else passed++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send_beat(1'b1);
        wait_pairs(4);
        repeat (6) @(posedge clk); #1;
        checks++; if (pairs.size() != 4) $display("FAIL bp_count got=%0d want=4", pairs.size()); else passed++;
        for (int k = 0; pairs.size() > 0; k++) begin
            pair_t p = pairs.pop_front();
            checks++; if (!p.have_exp || p.got_y != p.exp_y) $display("FAIL bp%0d_y got=%0d want=%0d", k, p.got_y, p.exp_y); else passed++;
            checks++; if (p.got_idx != base + k) $display("FAIL bp%0d_idx got=%0d want=%0d", k, p.got_idx, base + k); else passed++;
        end
        $display("backpressure: 4 beats, 5 stalled cycles");
    endtask

    task automatic test_wrap();
        apply_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin fill_random(); send_beat(k[0]); end
        wait_pairs(17);
        for (int k = 0; pairs.size() > 0; k++) begin
            pair_t p = pairs.pop_front();
            checks++; if (!p.have_exp || p.got_y != p.exp_y) $display("FAIL wrap%0d_y got=%0d want=%0d", k, p.got_y, p.exp_y); else passed++;
            checks++; if (p.got_idx2 != k % 16) $display("FAIL wrap%0d_idx4 got=%0d want=%0d", k, p.got_idx2, k % 16); else passed++;
            checks++; if (p.got_idx != k) $display("FAIL wrap%0d_idx got=%0d want=%0d", k, p.got_idx, k); else passed++;
        end
        $display("wrap: 17 transfers, alternating mode");
    endtask

    task automatic test_random();
        int n;
        for (int c = 0; c < 400; c++) begin
            fill_random();
            cfg_pool_max = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n = pairs.size() + exp_q.size();
        wait_pairs(n);
        for (int k = 0; pairs.size() > 0; k++) begin
            pair_t p = pairs.pop_front();
            checks++; if (!p.have_exp || p.got_y != p.exp_y) $display("FAIL rand%0d_y got=%0d want=%0d", k, p.got_y, p.exp_y); else passed++;
            checks++; if (p.got_idx != p.want_idx) $display("FAIL rand%0d_idx got=%0d want=%0d", k, p.got_idx, p.want_idx); else passed++;
        end
`ifdef CONV_POOL_SAT_CNT_EN
        checks++; if (int'(sat_cnt) != ref_sat) $display("FAIL rand_sat_cnt got=%0d want=%0d", sat_cnt, ref_sat); else passed++;
`endif
        $display("random: %0d transfers", n);
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        fill_uniform(10, 1); send_beat(1'b0);
        fill_uniform(20, 1); send_beat(1'b0);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got=%0b want=0", out_valid); else passed++;
        checks++; if (y !== '0) $display("FAIL mid_y got=%0d want=0", y); else passed++;
        checks++; if (out_idx !== '0) $display("FAIL mid_out_idx got=%0d want=0", out_idx); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL mid_in_ready got=%0b want=0", in_ready); else passed++;
        clear_bench_state();
        @(posedge clk); #1 rst = 1'b1;
        repeat (6) @(posedge clk); #1;
        checks++; if (pairs.size() != 0 || out_valid !== 1'b0) $display("FAIL mid_ghost got=%0d outputs want=0", pairs.size()); else passed++;
        fill_uniform(5, 1); send_beat(1'b1);
        wait_pairs(1);
        if (pairs.size() > 0) begin
            pair_t p = pairs.pop_front();
            checks++; if (p.got_y != 15) $display("FAIL mid_after_y got=%0d want=15", p.got_y); else passed++;
            checks++; if (p.got_idx != 0) $display("FAIL mid_after_idx got=%0d want=0", p.got_idx); else passed++;
        end
        $display("reset mid-stream: 2 beats discarded");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_wrap();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
